l_alu_complex: RTL and testbench
================================

Name: l_alu_complex

Overview:
- Registered 16-bit ALU for the Unicycle datapath.
- Decodes the raw 16-bit instruction word and computes a result from up to three 16-bit register operands (in0, in1, in2) plus an immediate taken from the instruction.
- Sits between the register-file read ports and the writeback mux; the result is registered once per clock.

Parameters:
- WIDTH, 16, operand/result width; fixed at 16; the instruction decode assumes 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- instruction  input  16  raw instruction word
- in0  input  16  first operand (rs)
- in1  input  16  second operand (rt)
- in2  input  16  third operand; used only by three-operand ops
- out  output  16  registered result

Behaviour:
- One clock domain. Reset is synchronous and active-high: reset=1 at a rising clk edge forces out=16'h0000. Reset wins over any instruction.
- Latency is 1 cycle. The combinational result of instruction/in0/in1/in2 sampled at rising edge N appears on out after edge N and holds until the next edge. There is no handshake; a new op is accepted every cycle.
- Decode fields: op=instruction[15:12]; funct=instruction[11:9]; imm6=instruction[11:6].
- op 0000, R-type; in2 is ignored:
  - funct 000 ADD: in0+in1
  - funct 001 SUB: in0-in1
  - funct 010 AND: in0&in1
  - funct 011 OR: in0|in1
  - funct 100 XOR: in0^in1
  - funct 101 SLL: in0<<in1[3:0]
  - funct 110 SRL: logical in0>>in1[3:0]
  - funct 111 SRA: arithmetic in0>>>in1[3:0]
- op 0001, three-operand:
  - funct 000 ADD3: in0+in1+in2
  - funct 001 SEL: (in2!=0) ? in0 : in1
  - funct 010 AND3: in0&in1&in2
  - funct 011 MUL: low 16 bits of in0*in1
  - other funct values give 0.
- op 0010 ADDI: in0 + sign-extended imm6. in1 and in2 are ignored.
- op 0011 ANDI: in0 & zero-extended imm6.
- op 0100 LUI: {instruction[7:0], 8'h00}.
- Any other op gives result 0 (no X propagation).
- Arithmetic is two's-complement modulo 2^16. Carry/overflow is discarded silently, and signed and unsigned addition give identical bits. Shift amounts use only in1[3:0]; in1[15:4] is ignored.
- Fields not used by an op (e.g. instruction[5:0] for ADDI, in2 for ADD/AND) must not affect out.
- If reset is deasserted mid-stream, the first result after the deasserting edge reflects the inputs at the next edge; no stale value is retained.

Test Plan:
- ADD, inst=16'h012E, in2=0: in0=0001/in1=0003 -> 0004; FFFF+FFF0 -> FFEF; 0001+FFFC -> FFFD. Each result appears one clk after the inputs are applied.
- AND, inst=16'h052E, in2=16'h0200 (must be ignored): 0001&0003 -> 0001; FFFF&FFF0 -> FFF0; 0001&FFFC -> 0000.
- ADDI, inst=16'h2080 (imm6=2), in0=0001, in1=in2=0 -> 0003. ADDI with imm6=6'b111111, in0=0000 -> FFFF.
- SUB, inst=16'h022E: 0003-0005 -> FFFE. SRA by in1=0004 on in0=8000 -> F800. SRL on the same operands -> 0800.
- ADD3 (inst=16'h1000) 0001+0002+0003 -> 0006. SEL (inst=16'h1200) in0=AAAA, in1=5555: in2=0 -> 5555, in2=0001 -> AAAA.
- Reset: hold reset=1 with ADD 0001+0003 -> out=0000. Release reset -> 0004 after the next edge. Undefined op inst=16'hF000 -> 0000.

Source files
------------

// File: rtl/l_alu_complex_if.sv
`default_nettype none
// ============================================================================
//  Module      : l_alu_complex_if
//  Description : Operand/instruction/result bundle between the register-file
//                read ports (master) and the Unicycle ALU (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface l_alu_complex_if #(
    parameter int WIDTH = 16
);
    logic [15:0]      instruction;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;

    // Operand source: drives the instruction word and operands, sees the result
    modport master (
        output instruction,
        output in0,
        output in1,
        output in2,
        input  out
    );

    // ALU side: consumes the instruction and operands, produces the result
    modport slave (
        input  instruction,
        input  in0,
        input  in1,
        input  in2,
        output out
    );
endinterface
`default_nettype wire

// File: rtl/l_alu_complex.sv
`default_nettype none
// ============================================================================
//  Module      : l_alu_complex
//  Description : Registered 16-bit ALU. Decodes the raw instruction word and
//                combines up to three register operands plus an immediate;
//                the result is registered once per clock (latency 1).
//  Revision    : 1.0  initial release
// ============================================================================
module l_alu_complex #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    l_alu_complex_if.slave        bus
);
    // Opcode encodings
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_THREE = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'b0010;
    localparam logic [3:0] OP_ANDI  = 4'b0011;
    localparam logic [3:0] OP_LUI   = 4'b0100;

    // R-type function encodings
    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;
    localparam logic [2:0] FN_XOR = 3'b100;
    localparam logic [2:0] FN_SLL = 3'b101;
    localparam logic [2:0] FN_SRL = 3'b110;
    localparam logic [2:0] FN_SRA = 3'b111;

    // Three-operand function encodings
    localparam logic [2:0] FN_ADD3 = 3'b000;
    localparam logic [2:0] FN_SEL  = 3'b001;
    localparam logic [2:0] FN_AND3 = 3'b010;
    localparam logic [2:0] FN_MUL  = 3'b011;

    logic [3:0]  op;
    logic [2:0]  funct;
    logic [5:0]  imm6;
    logic [3:0]  shamt;
    logic [15:0] imm_sext;
    logic [15:0] imm_zext;
    logic [15:0] result;
    logic [15:0] out_q;

    assign op       = bus.instruction[15:12];
    assign funct    = bus.instruction[11:9];
    assign imm6     = bus.instruction[11:6];
    // Only the low nibble of in1 is a meaningful shift distance for 16 bits
    assign shamt    = bus.in1[3:0];
    assign imm_sext = {{10{imm6[5]}}, imm6};
    assign imm_zext = {10'd0, imm6};

    // Decode and compute the next result; every undefined encoding yields zero
    always_comb begin
        result = 16'h0000;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  result = bus.in0 + bus.in1;
                    FN_SUB:  result = bus.in0 - bus.in1;
                    FN_AND:  result = bus.in0 & bus.in1;
                    FN_OR:   result = bus.in0 | bus.in1;
                    FN_XOR:  result = bus.in0 ^ bus.in1;
                    FN_SLL:  result = bus.in0 << shamt;
                    FN_SRL:  result = bus.in0 >> shamt;
                    FN_SRA:  result = $unsigned($signed(bus.in0) >>> shamt);
                    default: result = 16'h0000;
                endcase
            end
            OP_THREE: begin
                case (funct)
                    FN_ADD3: result = bus.in0 + bus.in1 + bus.in2;
                    FN_SEL:  result = (bus.in2 != 16'h0000) ? bus.in0 : bus.in1;
                    FN_AND3: result = bus.in0 & bus.in1 & bus.in2;
                    FN_MUL:  result = bus.in0 * bus.in1;
                    default: result = 16'h0000;
                endcase
            end
            OP_ADDI: result = bus.in0 + imm_sext;
            OP_ANDI: result = bus.in0 & imm_zext;
            OP_LUI:  result = {bus.instruction[7:0], 8'h00};
            default: result = 16'h0000;
        endcase
    end

    // Result register; reset takes priority over any instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= 16'h0000;
        end else begin
            out_q <= result;
        end
    end

    assign bus.out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_l_alu_complex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l_alu_complex
//  Description : Self-checking bench for l_alu_complex: directed cases from
//                the instruction set description followed by random ops
//                compared against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l_alu_complex;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    l_alu_complex_if #(.WIDTH(16)) bus ();

    l_alu_complex #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the instruction set semantics with plain integer arithmetic
    function automatic logic [15:0] ref_alu(input logic [15:0] inst,
                                            input logic [15:0] x,
                                            input logic [15:0] y,
                                            input logic [15:0] z);
        longint a, b, c, r, imm, sh, s, masked;
        int op, fn;
        a   = longint'(x);
        b   = longint'(y);
        c   = longint'(z);
        op  = int'(inst) / 4096;
        fn  = (int'(inst) / 512) % 8;
        imm = (longint'(inst) / 64) % 64;
        sh  = b % 16;
        r   = 0;
        case (op)
            0: case (fn)
                0: r = a + b;
                1: r = a - b;
                2: r = a & b;
                3: r = a | b;
                4: r = a ^ b;
                5: r = a * (longint'(1) << sh);
                6: r = a / (longint'(1) << sh);
                default: begin
                    s = (a >= 32768) ? a - 65536 : a;
                    r = s >>> sh;
                end
            endcase
            1: case (fn)
                0: r = a + b + c;
                1: r = (c != 0) ? a : b;
                2: r = a & b & c;
                3: r = a * b;
                default: r = 0;
            endcase
            2: r = a + ((imm >= 32) ? imm - 64 : imm);
            3: r = a & imm;
            4: r = (longint'(inst) % 256) * 256;
            default: r = 0;
        endcase
        masked = r & 64'h0000_0000_0000_FFFF;
        return masked[15:0];
    endfunction

    // Apply one set of inputs between edges, then sample 1 time unit after the edge
    task automatic step(input logic rst_v, input logic [15:0] inst,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z);
        @(negedge clk);
        reset           = rst_v;
        bus.instruction = inst;
        bus.in0         = x;
        bus.in1         = y;
        bus.in2         = z;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        n_cmp++;
        assert (bus.out === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, bus.out, exp);
        end
    endtask

    // Directed and randomized test sequence
    initial begin
        logic [15:0] inst, x, y, z, exp;
        logic [3:0]  op;
        logic        r;
        n_cmp  = 0;
        n_fail = 0;
        reset           = 1'b1;
        bus.instruction = 16'h0000;
        bus.in0         = 16'h0000;
        bus.in1         = 16'h0000;
        bus.in2         = 16'h0000;

        step(1'b1, 16'h012E, 16'h1234, 16'h4321, 16'h0000);
        check("reset_state", 16'h0000);

        // ADD
        step(1'b0, 16'h012E, 16'h0001, 16'h0003, 16'h0000); check("add_1_3", 16'h0004);
        step(1'b0, 16'h012E, 16'hFFFF, 16'hFFF0, 16'h0000); check("add_wrap", 16'hFFEF);
        step(1'b0, 16'h012E, 16'h0001, 16'hFFFC, 16'h0000); check("add_neg", 16'hFFFD);
        // AND with in2 set (ignored)
        step(1'b0, 16'h052E, 16'h0001, 16'h0003, 16'h0200); check("and_1_3", 16'h0001);
        step(1'b0, 16'h052E, 16'hFFFF, 16'hFFF0, 16'h0200); check("and_ff", 16'hFFF0);
        step(1'b0, 16'h052E, 16'h0001, 16'hFFFC, 16'h0200); check("and_zero", 16'h0000);
        // ADDI
        step(1'b0, 16'h2080, 16'h0001, 16'h0000, 16'h0000); check("addi_2", 16'h0003);
        step(1'b0, 16'h2FC0, 16'h0000, 16'h0000, 16'h0000); check("addi_m1", 16'hFFFF);
        step(1'b0, 16'h2FFF, 16'h0000, 16'h1111, 16'h2222); check("addi_lowbits", 16'hFFFF);
        // SUB and shifts
        step(1'b0, 16'h022E, 16'h0003, 16'h0005, 16'h0000); check("sub_neg", 16'hFFFE);
        step(1'b0, 16'h0E00, 16'h8000, 16'h0004, 16'h0000); check("sra_4", 16'hF800);
        step(1'b0, 16'h0C00, 16'h8000, 16'h0004, 16'h0000); check("srl_4", 16'h0800);
        step(1'b0, 16'h0A00, 16'h0001, 16'hFFF3, 16'h0000); check("sll_hi_ignored", 16'h0008);
        // Three-operand
        step(1'b0, 16'h1000, 16'h0001, 16'h0002, 16'h0003); check("add3", 16'h0006);
        step(1'b0, 16'h1200, 16'hAAAA, 16'h5555, 16'h0000); check("sel_in1", 16'h5555);
        step(1'b0, 16'h1200, 16'hAAAA, 16'h5555, 16'h0001); check("sel_in0", 16'hAAAA);
        step(1'b0, 16'h1600, 16'h0101, 16'h0100, 16'h0000); check("mul_low", 16'h0100);
        step(1'b0, 16'h1800, 16'hFFFF, 16'hFFFF, 16'hFFFF); check("three_undef", 16'h0000);
        // ANDI / LUI
        step(1'b0, 16'h3FC0, 16'hFFFF, 16'h0000, 16'h0000); check("andi_zext", 16'h003F);
        step(1'b0, 16'h40A5, 16'h1234, 16'h0000, 16'h0000); check("lui", 16'hA500);
        // Reset priority and release
        step(1'b1, 16'h012E, 16'h0001, 16'h0003, 16'h0000); check("reset_hold", 16'h0000);
        step(1'b0, 16'h012E, 16'h0001, 16'h0003, 16'h0000); check("reset_release", 16'h0004);
        // Undefined op
        step(1'b0, 16'hF000, 16'hFFFF, 16'hFFFF, 16'hFFFF); check("undef_op", 16'h0000);

        // Random ops, biased toward defined opcodes, with occasional reset
        for (int i = 0; i < 400; i++) begin
            op   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4))
                                              : 4'($urandom_range(5, 15));
            inst = {op, 12'($urandom)};
            x    = 16'($urandom);
            y    = 16'($urandom);
            z    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            r    = ($urandom_range(0, 24) == 0);
            exp  = r ? 16'h0000 : ref_alu(inst, x, y, z);
            step(r, inst, x, y, z);
            check($sformatf("rand_%0d_inst_%h", i, inst), exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
